// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Saturation constants are consumed only when DIGIT_SERIAL_ADDER_SAT_EN is defined.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest operand the saturation helpers can describe.
  localparam int SAT_MAX_W = 1024;

  function automatic int ndig_f(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w_f(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  // Largest positive two's-complement value of the given width: 0x7F..F.
  function automatic logic [SAT_MAX_W-1:0] sat_pos_f(input int width);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of the given width: 0x80..0.
  function automatic logic [SAT_MAX_W-1:0] sat_neg_f(input int width);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i == width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of full adders.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module digit_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/sub unit: one DIGIT-wide adder reused over WIDTH/DIGIT cycles.
// Define DIGIT_SERIAL_ADDER_SAT_EN to saturate sum on signed overflow.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig_f(WIDTH, DIGIT);
  localparam int CW   = cnt_w_f(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

`ifdef DIGIT_SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos_f(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg_f(WIDTH));

  // Wrapped result with MSB set means the true value overflowed upwards.
  function automatic logic [WIDTH-1:0] sat_f(input logic signed [WIDTH-1:0] r,
                                             input logic ovf_in);
    if (!ovf_in)          return r;
    else if (r[WIDTH-1])  return SAT_POS;
    else                  return SAT_NEG;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  res_sh_q, res_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DIGIT-1:0]  dig_sum;
  logic              dig_cout;
  logic              dig_c_msb;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a     (a_sh_q[DIGIT-1:0]),
    .b     (b_sh_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_c_msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Subtraction is a + ~b + ~cin, so invert B and the carry on capture.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        carry_d  = dig_cout;
        res_sh_d = (res_sh_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          ovf_d   = dig_c_msb ^ dig_cout;
          cout_d  = dig_cout;
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
          sum_d   = sat_f(res_sh_d, ovf_d);
`else
          sum_d   = res_sh_d;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed scenarios on DIGIT=4 plus a random sweep
// over DIGIT=4/1/8/32 instances sharing one stimulus stream.
module tb_digit_serial_adder;

  localparam int WIDTH = 32;
  localparam int NI    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic             cin   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;

  logic             busy_v [NI];
  logic             done_v [NI];
  logic             cout_v [NI];
  logic             ovf_v  [NI];
  logic [WIDTH-1:0] sum_v  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(8)) u_dut_d8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));
  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(32)) u_dut_d32 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

  function automatic int ndig_of(input int k);
    case (k)
      0:       return 8;
      1:       return 32;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: exact integer arithmetic, then reduce modulo 2^32 and range-check.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                input logic mcin, input logic msub,
                                output logic [31:0] s, output logic c, output logic o);
    longint ua, ub, sa, sb, u, t;
    longint smax, smin;
    smax = 64'sd2147483647;
    smin = -64'sd2147483648;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (!msub) begin
      u = ua + ub + longint'(mcin);
      t = sa + sb + longint'(mcin);
      c = (u > 64'sd4294967295);
    end else begin
      u = ua - ub - longint'(mcin);
      t = sa - sb - longint'(mcin);
      c = (u >= 0);
    end
    s = u[31:0];
    o = (t > smax) || (t < smin);
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    if (t > smax) s = 32'h7FFF_FFFF;
    else if (t < smin) s = 32'h8000_0000;
`endif
  endfunction

  // Drive one op on all instances, observe instance 0. Optionally hold start high
  // from cycle inj_from through inj_to with other operands.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                        input logic isub, input int inj_from, input int inj_to,
                        output int lat, output int pulses, output logic [31:0] s,
                        output logic c, output logic o, output logic [31:0] mid_sum);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    lat = -1; pulses = 0; s = '0; c = 1'b0; o = 1'b0; mid_sum = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == inj_from) begin
        start = 1'b1; a = ~ia; b = ib ^ 32'h5A5A_5A5A; cin = ~icin;
      end else if (n == 1 || n == inj_to + 1) begin
        start = 1'b0;
      end
      if (n == 3) mid_sum = sum_v[0];
      if (done_v[0]) begin
        pulses++;
        if (lat < 0) begin
          lat = n; s = sum_v[0]; c = cout_v[0]; o = ovf_v[0];
        end
      end
      if (lat >= 0 && n > lat + 14) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (busy_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy_v[k]); end
      n_checks++;
      if (done_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d] got %b want 0", k, done_v[k]); end
      n_checks++;
      if (sum_v[k] !== 32'h0) begin n_fail++; $display("FAIL reset_sum[%0d] got %h want 0", k, sum_v[k]); end
      n_checks++;
      if ({cout_v[k], ovf_v[k]} !== 2'b00) begin
        n_fail++; $display("FAIL reset_flags[%0d] got %b%b want 00", k, cout_v[k], ovf_v[k]);
      end
      n_checks++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry;
    int lat, pulses; logic [31:0] s, mid; logic c, o;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, lat, pulses, s, c, o, mid);
    if (lat !== 9) begin n_fail++; $display("FAIL add_carry_latency got %0d want 9", lat); end
    n_checks++;
    if (s !== 32'h0) begin n_fail++; $display("FAIL add_carry_sum got %h want 00000000", s); end
    n_checks++;
    if ({c, o} !== 2'b10) begin n_fail++; $display("FAIL add_carry_flags cout/ovf got %b%b want 10", c, o); end
    n_checks++;
  endtask

  task automatic test_overflow;
    int lat, pulses; logic [31:0] s, mid, exp_s; logic c, o;
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    exp_s = 32'h7FFF_FFFF;
`else
    exp_s = 32'h8000_0000;
`endif
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, lat, pulses, s, c, o, mid);
    if (s !== exp_s) begin n_fail++; $display("FAIL ovf_sum got %h want %h", s, exp_s); end
    n_checks++;
    if ({c, o} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags cout/ovf got %b%b want 01", c, o); end
    n_checks++;
    if (mid !== 32'h0) begin n_fail++; $display("FAIL ovf_sum_held_in_run got %h want 00000000", mid); end
    n_checks++;
  endtask

  task automatic test_sub_borrow;
    int lat, pulses; logic [31:0] s, mid, prev; logic c, o;
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    prev = 32'h7FFF_FFFF;
`else
    prev = 32'h8000_0000;
`endif
    run_op(32'd5, 32'd7, 1'b1, 1'b1, 0, 0, lat, pulses, s, c, o, mid);
    if (mid !== prev) begin n_fail++; $display("FAIL sub_sum_held_in_run got %h want %h", mid, prev); end
    n_checks++;
    if (s !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sub_sum got %h want fffffffd", s); end
    n_checks++;
    if ({c, o} !== 2'b00) begin n_fail++; $display("FAIL sub_flags cout/ovf got %b%b want 00", c, o); end
    n_checks++;
  endtask

  task automatic test_reset_mid_op;
    int lat, pulses, stray; logic [31:0] s, mid; logic c, o;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL midop_busy_before_reset got %b want 1", busy_v[0]); end
    n_checks++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    if ({busy_v[0], done_v[0]} !== 2'b00) begin
      n_fail++; $display("FAIL midop_reset_ctrl busy/done got %b%b want 00", busy_v[0], done_v[0]);
    end
    n_checks++;
    if (sum_v[0] !== 32'h0) begin n_fail++; $display("FAIL midop_reset_sum got %h want 0", sum_v[0]); end
    n_checks++;
    rst_n = 1'b1;
    stray = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) stray++;
    end
    if (stray !== 0) begin n_fail++; $display("FAIL midop_no_done_after_abort got %0d active cycles want 0", stray); end
    n_checks++;
    run_op(32'h0000_00FF, 32'h0000_0F01, 1'b1, 1'b0, 0, 0, lat, pulses, s, c, o, mid);
    if (s !== 32'h0000_1001 || lat !== 9) begin
      n_fail++; $display("FAIL midop_recover sum=%h lat=%0d want sum=00001001 lat=9", s, lat);
    end
    n_checks++;
  endtask

  task automatic test_start_while_busy;
    int lat, pulses; logic [31:0] s, mid, es; logic c, o, ec, eo;
    model(32'h0F0F_0F0F, 32'h1234_4321, 1'b1, 1'b0, es, ec, eo);
    run_op(32'h0F0F_0F0F, 32'h1234_4321, 1'b1, 1'b0, 3, 9, lat, pulses, s, c, o, mid);
    if (pulses !== 1) begin n_fail++; $display("FAIL busy_start_pulses got %0d want 1", pulses); end
    n_checks++;
    if (s !== es || c !== ec || o !== eo) begin
      n_fail++; $display("FAIL busy_start_result got %h/%b/%b want %h/%b/%b", s, c, o, es, ec, eo);
    end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL busy_start_latency got %0d want 9", lat); end
    n_checks++;
  endtask

  task automatic test_random_sweep;
    logic [31:0] bt_a [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] bt_b [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] es; logic ec, eo;
    int lat [NI]; int pulses [NI];
    int idle_wait;
    for (int it = 0; it < 24; it++) begin
      idle_wait = 0;
      while ((busy_v[0] || busy_v[1] || busy_v[2] || busy_v[3] ||
              done_v[0] || done_v[1] || done_v[2] || done_v[3]) && idle_wait < 80) begin
        @(posedge clk); #1; idle_wait++;
      end
      if (idle_wait >= 80) begin n_fail++; $display("FAIL sweep_idle_timeout it=%0d got busy want idle", it); end
      n_checks++;
      if (it < 4) begin a = bt_a[it]; b = bt_b[it]; end
      else begin a = $urandom; b = $urandom; end
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      model(a, b, cin, sub, es, ec, eo);
      for (int k = 0; k < NI; k++) begin lat[k] = -1; pulses[k] = 0; end
      start = 1'b1;
      for (int n = 1; n <= 45; n++) begin
        @(posedge clk); #1;
        if (n == 1) start = 1'b0;
        for (int k = 0; k < NI; k++) begin
          if (done_v[k]) begin
            pulses[k]++;
            if (lat[k] < 0) begin
              lat[k] = n;
              if (sum_v[k] !== es || cout_v[k] !== ec || ovf_v[k] !== eo) begin
                n_fail++;
                $display("FAIL sweep_result it=%0d inst=%0d got %h/%b/%b want %h/%b/%b",
                         it, k, sum_v[k], cout_v[k], ovf_v[k], es, ec, eo);
              end
              n_checks++;
            end
          end
        end
      end
      for (int k = 0; k < NI; k++) begin
        if (lat[k] !== ndig_of(k) + 1 || pulses[k] !== 1) begin
          n_fail++;
          $display("FAIL sweep_latency it=%0d inst=%0d got lat=%0d pulses=%0d want lat=%0d pulses=1",
                   it, k, lat[k], pulses[k], ndig_of(k) + 1);
        end
        n_checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_overflow();
    test_sub_borrow();
    test_reset_mid_op();
    test_start_while_busy();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
